dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_rr_pick2.sv | 16 +
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  // Arbiter FSM: plain round-robin, or port 1 holding the memory.
  typedef enum logic {
    ST_RR    = 1'b0,
    ST_LOCK1 = 1'b1
  } state_t;

  // Port index. Used for last_grant and for the response owner bit.
  typedef logic port_idx_t;
  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

  // Access size codes, as they appear in the RISC-V funct3 field.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester round-robin pick. On a tie, the port that was not granted
// most recently wins.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t last_grant,
  output logic      gnt0,
  output logic      gnt1
);

  assign gnt0 = req0 && (!req1 || (last_grant == PORT1));
  assign gnt1 = req1 && (!req0 || (last_grant == PORT0));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter. Port 0 (pipeline load/store) and port 1 (debug/loader)
// share a single combinational-read memory. Each cycle at most one access is
// accepted. Load data is registered into a single shared response register,
// and a registered owner bit routes the rvalid pulse to the right port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [2:0]            p0_funct3,
  output logic                  p0_rvalid,
  output logic [DATA_W-1:0]     p0_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [2:0]            p1_funct3,
  input  logic                  p1_lock,
  output logic                  p1_rvalid,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  state_t          state, state_nxt;
  port_idx_t       last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic            rr_gnt0, rr_gnt1;
  logic            gnt0, gnt1;
  logic            at_max;
  logic            load_acc;
  logic            resp_valid;
  port_idx_t       resp_owner;
  logic [DATA_W-1:0] resp_data;

  rr_pick2 u_pick (
    .req0       (p0_valid),
    .req1       (p1_valid),
    .last_grant (last_grant),
    .gnt0       (rr_gnt0),
    .gnt1       (rr_gnt1)
  );

  assign at_max   = (lock_cnt >= CNT_MAX);
  assign load_acc = (gnt0 && !p0_we) || (gnt1 && !p1_we);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking, so all registers
    // sample the same pre-edge values and the order of the statements does
    // not matter.
    if (reset) state <= ST_RR;
    else       state <= state_nxt;
  end

  // Next-state logic. The lock is released when p1 drops p1_lock, or when
  // the lock has used up its budget and port 0 is waiting.
  always_comb begin
    // NOTE: give every combinationally assigned signal a default first, so
    // that no path through the block leaves it unassigned and infers a latch.
    state_nxt = state;
    unique case (state)
      ST_RR:    if (gnt1 && p1_lock) state_nxt = ST_LOCK1;
      ST_LOCK1: if (!p1_lock || (at_max && p0_valid)) state_nxt = ST_RR;
      default:  state_nxt = ST_RR;
    endcase
  end

  // Grant selection and the memory-side mux. A port is granted only while
  // its valid is high, so ready doubles as the acceptance strobe. No grant is
  // issued while reset is high.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    mem_funct3 = '0;
    if (!reset) begin
      unique case (state)
        ST_RR: begin
          gnt0 = rr_gnt0;
          gnt1 = rr_gnt1;
        end
        ST_LOCK1: begin
          if (!p1_lock) begin
            // The lock is dropped this cycle, so arbitrate as round-robin.
            gnt0 = rr_gnt0;
            gnt1 = rr_gnt1;
          end else if (at_max && p0_valid) begin
            gnt0 = 1'b1;
          end else if (p1_valid) begin
            gnt1 = 1'b1;
          end else begin
            // Port 1 is idle but still holds the lock. Port 0 may use the
            // free slot.
            gnt0 = p0_valid;
          end
        end
        default: ;
      endcase
    end
    if (gnt0) begin
      MemRead    = !p0_we;
      MemWrite   = p0_we;
      mem_a      = p0_addr;
      mem_wd     = p0_wdata;
      mem_funct3 = p0_funct3;
    end else if (gnt1) begin
      MemRead    = !p1_we;
      MemWrite   = p1_we;
      mem_a      = p1_addr;
      mem_wd     = p1_wdata;
      mem_funct3 = p1_funct3;
    end
  end

  // Fairness history and the lock counter. lock_cnt counts consecutive
  // port-1 grants under lock and saturates at MAX_LOCK.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT1;
      lock_cnt   <= '0;
    end else begin
      if (gnt0)      last_grant <= PORT0;
      else if (gnt1) last_grant <= PORT1;

      if (state == ST_RR)
        lock_cnt <= (gnt1 && p1_lock) ? CNT_W'(1) : '0;
      else if (state_nxt == ST_RR)
        lock_cnt <= '0;
      else if (gnt1 && !at_max)
        lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Shared load-response register. Data is captured at the acceptance edge
  // and held until the next load. rvalid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_owner <= PORT0;
      resp_data  <= '0;
    end else begin
      resp_valid <= load_acc;
      if (load_acc) begin
        resp_data  <= mem_rd;
        resp_owner <= gnt1 ? PORT1 : PORT0;
      end
    end
  end

  assign p0_ready  = gnt0;
  assign p1_ready  = gnt1;
  assign p0_rvalid = resp_valid && (resp_owner == PORT0);
  assign p1_rvalid = resp_valid && (resp_owner == PORT1);
  assign p0_rdata  = resp_data;
  assign p1_rdata  = resp_data;

endmodule
